// File: rtl/mips_pkg.sv
// Definitions shared by the single-cycle MIPS control unit and the boot-time
// program loader: the decoded opcode set and the loader state encoding.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_RECV  = 2'd1,
    LD_WRITE = 2'd2,
    LD_DONE  = 2'd3
  } ld_state_e;

endpackage

// File: rtl/imem_opcode_check.sv
// Flags whether a 6-bit opcode is one the control unit decodes.
module imem_opcode_check
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       legal
);

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: legal = 1'b1;
      default:                                       legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: assembles big-endian words from a byte stream, writes them
// to consecutive instruction-memory addresses and stalls the core meanwhile.
//
// state    | meaning
// ---------+-----------------------------------------------
// LD_IDLE  | waiting for start; core runs
// LD_RECV  | accepting the four bytes of the current word
// LD_WRITE | one-cycle write strobe of the assembled word
// LD_DONE  | one-cycle done pulse, then back to idle
module imem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              hold,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   bad_op_cnt
);

  ld_state_e         state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W:0]   bad_q, bad_d;
  logic              zdone_q, zdone_d;

  logic              op_legal;
  logic [ADDR_W:0]   word_cnt_inc;

  imem_opcode_check u_opcode_check (
    .opcode (word_q[31:26]),
    .legal  (op_legal)
  );

  assign word_cnt_inc = word_cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= LD_IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      addr_q     <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      bad_q      <= '0;
      zdone_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      addr_q     <= addr_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      bad_q      <= bad_d;
      zdone_q    <= zdone_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    addr_d     = addr_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    bad_d      = bad_q;
    zdone_d    = 1'b0;

    case (state_q)
      LD_IDLE: begin
        if (start) begin
          bad_d = '0;
          if (load_len != '0) begin
            len_d      = load_len;
            word_cnt_d = '0;
            addr_d     = '0;
            byte_cnt_d = '0;
            state_d    = LD_RECV;
          end else begin
            // empty load: acknowledge without ever stalling the core
            zdone_d = 1'b1;
          end
        end
      end
      LD_RECV: begin
        if (in_valid) begin
          word_d     = {word_q[23:0], in_data};
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == 2'd3) begin
            state_d = LD_WRITE;
          end
        end
      end
      LD_WRITE: begin
        if (!op_legal) begin
          bad_d = bad_q + 1'b1;
        end
        if (word_cnt_inc == len_q) begin
          state_d = LD_DONE;
        end else begin
          // address wraps naturally when the length exceeds the memory
          addr_d     = addr_q + 1'b1;
          word_cnt_d = word_cnt_inc;
          byte_cnt_d = '0;
          state_d    = LD_RECV;
        end
      end
      LD_DONE: begin
        state_d = LD_IDLE;
      end
      default: begin
        state_d = LD_IDLE;
      end
    endcase
  end

  assign in_ready   = (state_q == LD_RECV);
  assign imem_we    = (state_q == LD_WRITE);
  assign imem_addr  = addr_q;
  assign imem_wdata = word_q;
  assign hold       = (state_q != LD_IDLE);
  assign busy       = (state_q != LD_IDLE);
  assign done       = (state_q == LD_DONE) || zdone_q;
  assign bad_op_cnt = bad_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized bench for imem_loader with a cycle-schedule reference
// model and a shadow instruction memory.
module tb_imem_loader;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int SLOTS = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   load_len;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          hold;
  logic          busy;
  logic          done;
  logic [AW:0]   bad_op_cnt;

  int errors = 0;
  int checks = 0;

  logic [31:0] words   [8];
  logic [31:0] dut_mem [DEPTH];
  logic [31:0] exp_mem [DEPTH];
  logic [5:0]  legal_ops [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};

  imem_loader #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .load_len   (load_len),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .hold       (hold),
    .busy       (busy),
    .done       (done),
    .bad_op_cnt (bad_op_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] all_outs();
    return 64'({in_ready, imem_we, hold, busy, done, imem_addr, imem_wdata, bad_op_cnt});
  endfunction

  // Plans the exact cycle of every byte acceptance and write from the timing
  // rules, drives that plan, and compares what the DUT did against it.
  task automatic do_load(input string name, input int n, input int bub_pct, input int abort_rel);
    bit          sv   [SLOTS];
    bit          junk [SLOTS];
    logic [7:0]  sd   [SLOTS];
    bit          hold_at [SLOTS];
    bit          busy_at [SLOTS];
    int          wcyc [8];
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    int          wc[$];
    int t, exp_done, exp_bad, exp_nw, ndone, done_at, last_rel;
    bit any_hold, any_busy;

    foreach (sv[i]) begin sv[i] = 1'b0; junk[i] = 1'b0; sd[i] = 8'h00; end
    t = 1;
    for (int w = 0; w < n; w++) begin
      for (int b = 0; b < 4; b++) begin
        while ($urandom_range(0, 99) < bub_pct) t++;
        sv[t] = 1'b1;
        sd[t] = words[w][31-8*b -: 8];
        t++;
      end
      wcyc[w] = t;
      junk[t] = 1'b1;
      t++;
    end
    exp_done = t;
    junk[t]  = 1'b1;

    exp_bad = 0;
    exp_nw  = 0;
    for (int w = 0; w < n; w++) begin
      if (abort_rel == 0 || wcyc[w] < abort_rel) begin
        exp_nw++;
        exp_mem[w % DEPTH] = words[w];
        if (!is_legal(words[w][31:26])) exp_bad++;
      end
    end

    last_rel = (abort_rel != 0) ? abort_rel : t + 2;
    ndone = 0; done_at = -1; any_hold = 1'b0; any_busy = 1'b0;

    for (int rel = 0; rel <= last_rel; rel++) begin
      if (abort_rel != 0 && rel == abort_rel) begin
        rst = 1'b0;
        #1;
        check({name, "_abort_outs"}, all_outs(), 64'd0);
        break;
      end
      hold_at[rel] = hold;
      busy_at[rel] = busy;
      any_hold |= hold;
      any_busy |= busy;
      if (imem_we) begin
        wa.push_back(32'(imem_addr));
        wd.push_back(imem_wdata);
        wc.push_back(rel);
        dut_mem[imem_addr] = imem_wdata;
      end
      if (done) begin ndone++; done_at = rel; end
      start    = (rel == 0) || (rel == 3 && n > 0);
      load_len = (rel == 0) ? (AW+1)'(n) : (AW+1)'($urandom());
      in_valid = sv[rel] || junk[rel];
      in_data  = sv[rel] ? sd[rel] : 8'($urandom());
      @(negedge clk);
    end
    start    = 1'b0;
    in_valid = 1'b0;

    check({name, "_nwrites"}, 64'(wa.size()), 64'(exp_nw));
    for (int i = 0; i < exp_nw && i < wa.size(); i++) begin
      check($sformatf("%s_addr%0d", name, i), 64'(wa[i]), 64'(i % DEPTH));
      check($sformatf("%s_data%0d", name, i), 64'(wd[i]), 64'(words[i]));
      check($sformatf("%s_wcyc%0d", name, i), 64'(wc[i]), 64'(wcyc[i]));
    end
    if (abort_rel == 0) begin
      check({name, "_ndone"},   64'(ndone),   64'd1);
      check({name, "_done_at"}, 64'(done_at), 64'(exp_done));
      check({name, "_hold_after"}, 64'(hold_at[exp_done+1]), 64'd0);
      check({name, "_busy_after"}, 64'(busy_at[exp_done+1]), 64'd0);
      check({name, "_bad_cnt"}, 64'(bad_op_cnt), 64'(exp_bad));
      if (n == 0) begin
        check({name, "_no_hold"}, 64'(any_hold), 64'd0);
        check({name, "_no_busy"}, 64'(any_busy), 64'd0);
      end else begin
        check({name, "_hold_done"}, 64'(hold_at[exp_done]), 64'd1);
      end
    end
    for (int a = 0; a < DEPTH; a++)
      check($sformatf("%s_mem%0d", name, a), 64'(dut_mem[a]), 64'(exp_mem[a]));
  endtask

  initial begin
    int nwr;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; load_len = '0; in_data = '0;
    foreach (dut_mem[i]) begin dut_mem[i] = '0; exp_mem[i] = '0; end
    #12;
    check("reset_outs", all_outs(), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    words[0] = 32'h8C010004; words[1] = 32'h20020005;
    do_load("two_word", 2, 0, 0);

    words[0] = 32'hFC000000; words[1] = 32'h00221820; words[2] = 32'h3C010001;
    do_load("illegal", 3, 0, 0);

    words[0] = 32'hAC220008;
    do_load("bubbles", 1, 50, 0);

    do_load("zero_len", 0, 0, 0);

    words[0] = 32'h10220003; words[1] = 32'h08000010; words[2] = 32'h00000000;
    do_load("abort", 3, 0, 8);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    nwr = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom());
      @(negedge clk);
      if (imem_we || in_ready) nwr++;
    end
    in_valid = 1'b0;
    check("abort_no_activity", 64'(nwr), 64'd0);
    check("abort_bad_cleared", 64'(bad_op_cnt), 64'd0);

    for (int i = 0; i < 5; i++) words[i] = {legal_ops[i], 26'(32'h0155_0000 + 32'(i))};
    do_load("wrap", 5, 0, 0);

    for (int it = 0; it < 4; it++) begin
      int n;
      n = $urandom_range(1, 7);
      for (int w = 0; w < n; w++) begin
        words[w] = $urandom();
        if ($urandom_range(0, 1) == 1) words[w][31:26] = legal_ops[$urandom_range(0, 5)];
      end
      do_load($sformatf("rand%0d", it), n, 30, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the single-cycle MIPS core. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. Each word is written into instruction memory at consecutive word addresses. While loading, it drives `hold` into the control unit's `Enable` input, which forces all control signals to their inert values. It also counts loaded words whose opcode the control unit does not decode.

## Interface
- `ADDR_W`, default 8: instruction-memory word-address width.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a load; sampled only in IDLE.
- `load_len`  in  ADDR_W+1  number of words to load; sampled with `start`.
- `in_valid`  in  1  `in_data` is valid.
- `in_data`  in  8  instruction byte, most significant byte of each word first.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  instruction-memory write strobe.
- `imem_addr`  out  ADDR_W  word address.
- `imem_wdata`  out  32  assembled instruction word.
- `hold`  out  1  connected to the control unit's `Enable`; high stalls the core.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  single-cycle pulse at the end of a load.
- `bad_op_cnt`  out  ADDR_W+1  count of words with an undecoded opcode in the current or last load.

## Operation
- States are IDLE, RECV, WRITE and DONE.
- **IDLE**
  - `start` with `load_len` != 0: latch the length, clear word count, address, byte count and `bad_op_cnt`, then go to RECV.
  - `start` with `load_len` == 0: clear `bad_op_cnt` and pulse `done` in the following cycle without leaving IDLE. `hold` stays low.
- **RECV**
  - `in_ready` = 1.
  - On `in_valid && in_ready`, the byte enters the shift register: `word <= {word[23:0], in_data}`, and the byte count increments.
  - On acceptance of the 4th byte, go to WRITE.
- **WRITE**
  - `imem_we` = 1 for exactly one cycle, with `imem_addr` and `imem_wdata` stable. `in_ready` = 0.
  - If `imem_wdata[31:26]` is not one of 000000, 100011, 101011, 000100, 001000 or 000010, `bad_op_cnt` increments.
  - If this was the last word (word count + 1 == length), go to DONE.
  - Otherwise increment the address and word count, clear the byte count, and go to RECV.
- **DONE**
  - `done` = 1 for one cycle, then go to IDLE.
- `hold` = 1 in RECV, WRITE and DONE; 0 in IDLE.
- `start` outside IDLE is ignored.
- Address and counter arithmetic is modulo 2^ADDR_W for the address and 2^(ADDR_W+1) for the counters.
  - `load_len` > 2^ADDR_W wraps the address to 0 and overwrites earlier words. This is a defined behaviour, not an error.
- The upstream source may change `in_data` or drop `in_valid` freely while `in_ready` = 0; no byte is consumed then.
- `bad_op_cnt` holds its value in IDLE until the next `start`.

## Timing
- Reset (`rst` = 0, asynchronous) forces:
  - state IDLE;
  - `in_ready`, `imem_we`, `hold`, `busy`, `done` = 0;
  - `imem_addr`, `imem_wdata`, `bad_op_cnt` = 0.
- Reset mid-load discards the partial word. Words already written stay in memory.
- All outputs are registered or decoded from state only; none depends combinationally on `in_valid`.
- Start cycle 0 is the cycle `start` is sampled.
  - RECV is entered in cycle 1.
  - With `in_valid` held high, the bytes of word k are accepted in cycles 5k+1..5k+4, and its WRITE occurs in cycle 5k+5.
  - For N words, `done` pulses in cycle 5N+1, and `hold` falls in cycle 5N+2.
- Each cycle of `in_valid` = 0 in RECV adds exactly one cycle of latency.

## Structure
- Shared package `mips_pkg`:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI and OP_J, also used by the control unit;
  - loader state enum.
- Sub-module `imem_opcode_check`: combinational; a 6-bit opcode in, `legal` out. It is reusable by the control-unit bench.

## Test plan
- **Two-word load:** reset, then `start` with `load_len` = 2 and bytes 8C 01 00 04 20 02 00 05 with `in_valid` held high.
  - Writes 0x8C010004 @0 in cycle 5 and 0x20020005 @1 in cycle 10.
  - `done` in cycle 11, `hold` low in cycle 12, `bad_op_cnt` = 0.
- **Illegal opcodes:** load 3 words 0xFC000000, 0x00221820, 0x3C010001 -> `bad_op_cnt` = 2.
- **Backpressure/bubbles:** `in_valid` toggles 1,0,1,0 during a 1-word load -> same word written, `imem_we` asserted exactly once, `done` delayed by the bubble count.
- **Zero length:** `start` with `load_len` = 0 -> `done` in cycle 1, `hold` and `busy` never asserted, no write.
- **Reset mid-load and ignored start:** assert `rst` = 0 after 2 bytes of word 1 of a 3-word load -> all outputs 0 immediately and no further writes. A second `start` while busy has no effect.
- **Wrap-around:** with ADDR_W = 2, load 5 words -> the fifth word is written to address 0.
